// File: rtl/wcf_pkg.sv
// Shared types and width helpers for the width-converting FIFO.
package wcf_pkg;

  typedef enum logic {
    WCF_DOWN = 1'b0,
    WCF_UP   = 1'b1
  } wcf_mode_e;

  function automatic bit is_up_f(input int unsigned mode);
    return mode == 32'(WCF_UP);
  endfunction

  function automatic int unsigned ww_f(input int unsigned mode, input int unsigned dw,
                                       input int unsigned ratio);
    return is_up_f(mode) ? dw : ratio * dw;
  endfunction

  function automatic int unsigned rw_f(input int unsigned mode, input int unsigned dw,
                                       input int unsigned ratio);
    return is_up_f(mode) ? ratio * dw : dw;
  endfunction

  // Narrow-unit pointer width: slot address + lane bits + one wrap bit.
  function automatic int unsigned ptr_w_f(input int unsigned aw, input int unsigned ratio);
    return aw + 32'($clog2(ratio)) + 1;
  endfunction

endpackage

// File: rtl/wcf_ctrl.sv
// Pointer, occupancy and flag control for width_conv_fifo.
// Optional occupancy output under WCF_LEVEL_EN.
module wcf_ctrl
  import wcf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RATIO      = 2,
  parameter int unsigned MODE       = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        wr_i,
  input  logic                                        rd_i,
  output logic                                        wr_acc_c_o,
  output logic [ptr_w_f(ADDR_WIDTH, RATIO)-2:0]       waddr_o,
  output logic [ptr_w_f(ADDR_WIDTH, RATIO)-2:0]       raddr_o,
  output logic                                        full_o,
  output logic                                        empty_o
`ifdef WCF_LEVEL_EN
  ,
  output logic [ptr_w_f(ADDR_WIDTH, RATIO)-1:0]       level_o
`endif
);

  localparam int unsigned PW   = ptr_w_f(ADDR_WIDTH, RATIO);
  localparam int unsigned CAP  = RATIO << ADDR_WIDTH;
  localparam bit          UP   = is_up_f(MODE);
  localparam int unsigned WINC = UP ? 1 : RATIO;
  localparam int unsigned RINC = UP ? RATIO : 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          rd_acc;

  // Acceptance uses the pre-edge flags; reset overrides both sides.
  assign wr_acc_c_o = wr_i & ~full_q & ~reset;
  assign rd_acc     = rd_i & ~empty_q & ~reset;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc_c_o) wptr_d = wptr_q + PW'(WINC);
    if (rd_acc)     rptr_d = rptr_q + PW'(RINC);
    count_d = wptr_d - rptr_d;
    if (UP) begin
      full_d  = (count_d == PW'(CAP));
      empty_d = (count_d < PW'(RATIO));
    end else begin
      full_d  = ((PW'(CAP) - count_d) < PW'(RATIO));
      empty_d = (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

`ifdef WCF_LEVEL_EN
  logic [PW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign level_o = count_q;
`endif

  assign waddr_o = wptr_q[PW-2:0];
  assign raddr_o = rptr_q[PW-2:0];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/width_conv_fifo.sv
// Width-converting first-word-fall-through FIFO (downsize or upsize by RATIO).
// Define WCF_LEVEL_EN to expose the stored narrow-unit count on level.
module width_conv_fifo
  import wcf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 2,
  parameter int unsigned MODE       = 0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          wr,
  input  logic                                          rd,
  input  logic [ww_f(MODE, DATA_WIDTH, RATIO)-1:0]      w_data,
  output logic [rw_f(MODE, DATA_WIDTH, RATIO)-1:0]      r_data,
  output logic                                          full,
  output logic                                          empty
`ifdef WCF_LEVEL_EN
  ,
  output logic [ptr_w_f(ADDR_WIDTH, RATIO)-1:0]         level
`endif
);

  localparam int unsigned AW  = ptr_w_f(ADDR_WIDTH, RATIO) - 1;
  localparam int unsigned CAP = RATIO << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [CAP];
  logic                  wr_acc;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;

  wcf_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RATIO      (RATIO),
    .MODE       (MODE)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .wr_i       (wr),
    .rd_i       (rd),
    .wr_acc_c_o (wr_acc),
    .waddr_o    (waddr),
    .raddr_o    (raddr),
    .full_o     (full),
    .empty_o    (empty)
`ifdef WCF_LEVEL_EN
    ,
    .level_o    (level)
`endif
  );

  // Storage is narrow-unit addressed; wide accesses are always slot-aligned.
  if (is_up_f(MODE)) begin : g_up
    always_ff @(posedge clk) begin
      if (wr_acc) mem_q[waddr] <= w_data;
    end

    always_comb begin
      r_data = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
        r_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr + AW'(k)];
      end
    end
  end else begin : g_down
    always_ff @(posedge clk) begin
      if (wr_acc) begin
        for (int unsigned k = 0; k < RATIO; k++) begin
          mem_q[waddr + AW'(k)] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign r_data = mem_q[raddr];
  end

endmodule

// File: tb/tb_width_conv_fifo.sv
// Scoreboard bench: one downsizing and one upsizing instance against a byte-queue model.
module tb_width_conv_fifo;

  localparam int CAP = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        wr_dn = 1'b0, rd_dn = 1'b0;
  logic [15:0] wd_dn = '0;
  logic [7:0]  rdata_dn;
  logic        full_dn, empty_dn;

  logic        wr_up = 1'b0, rd_up = 1'b0;
  logic [7:0]  wd_up = '0;
  logic [15:0] rdata_up;
  logic        full_up, empty_up;

`ifdef WCF_LEVEL_EN
  logic [4:0]  level_dn, level_up;
`endif

  width_conv_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2), .MODE(0)) u_dn (
    .clk(clk), .reset(reset), .wr(wr_dn), .rd(rd_dn), .w_data(wd_dn), .r_data(rdata_dn),
    .full(full_dn), .empty(empty_dn)
`ifdef WCF_LEVEL_EN
    , .level(level_dn)
`endif
  );

  width_conv_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO(2), .MODE(1)) u_up (
    .clk(clk), .reset(reset), .wr(wr_up), .rd(rd_up), .w_data(wd_up), .r_data(rdata_up),
    .full(full_up), .empty(empty_up)
`ifdef WCF_LEVEL_EN
    , .level(level_up)
`endif
  );

  int total = 0;
  int bad = 0;

  // Model: each FIFO is simply an ordered queue of bytes.
  logic [7:0]  qd[$];
  logic [7:0]  qu[$];
  logic [7:0]  exp_dn[$];
  logic [15:0] exp_up[$];
  int cur_dn = 0, cur_up = 0;
  int wcnt_dn = 0, rcnt_dn = 0, wcnt_up = 0, rcnt_up = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_dn(input bit w, input bit r, input logic [15:0] d);
    int n = qd.size();
    bit aw = w && (CAP - n >= 2);
    bit ar = r && (n > 0);
    cur_dn = n;
    if (ar) begin
      exp_dn.push_back(qd.pop_front());
      rcnt_dn++;
    end
    if (aw) begin
      qd.push_back(d[7:0]);
      qd.push_back(d[15:8]);
      wcnt_dn++;
    end
    wr_dn = w; rd_dn = r; wd_dn = d;
  endtask

  task automatic set_up(input bit w, input bit r, input logic [7:0] d);
    int n = qu.size();
    bit aw = w && (n < CAP);
    bit ar = r && (n >= 2);
    logic [7:0] b0, b1;
    cur_up = n;
    if (ar) begin
      b0 = qu.pop_front();
      b1 = qu.pop_front();
      exp_up.push_back({b1, b0});
      rcnt_up++;
    end
    if (aw) begin
      qu.push_back(d);
      wcnt_up++;
    end
    wr_up = w; rd_up = r; wd_up = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit dw, input bit dr, input logic [15:0] dd,
                     input bit uw, input bit ur, input logic [7:0] ud);
    set_dn(dw, dr, dd);
    set_up(uw, ur, ud);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 16'h0, 0, 0, 8'h0);
    reset = 1'b0;
    qd.delete();
    qu.delete();
    wcnt_dn = 0; rcnt_dn = 0; wcnt_up = 0; rcnt_up = 0;
  endtask

  // Monitor: flags every cycle, r_data whenever a read is being taken.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dn_full",  32'(full_dn),  32'(CAP - cur_dn < 2));
      chk("dn_empty", 32'(empty_dn), 32'(cur_dn == 0));
      chk("up_full",  32'(full_up),  32'(cur_up == CAP));
      chk("up_empty", 32'(empty_up), 32'(cur_up < 2));
`ifdef WCF_LEVEL_EN
      chk("dn_level", 32'(level_dn), 32'(cur_dn));
      chk("up_level", 32'(level_up), 32'(cur_up));
`endif
      if (rd_dn && !empty_dn) begin
        if (exp_dn.size() == 0) begin
          total++; bad++;
          $display("FAIL dn_unexpected_read: got %h want none at %0t", rdata_dn, $time);
        end else chk("dn_rdata", 32'(rdata_dn), 32'(exp_dn.pop_front()));
      end
      if (rd_up && !empty_up) begin
        if (exp_up.size() == 0) begin
          total++; bad++;
          $display("FAIL up_unexpected_read: got %h want none at %0t", rdata_up, $time);
        end else chk("up_rdata", 32'(rdata_up), 32'(exp_up.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_empty_dn", 32'(empty_dn), 32'd1);
    chk("reset_full_up",  32'(full_up),  32'd0);

    // Downsize: one wide word read back as two lanes, lane 0 first.
    cyc(1, 0, 16'hBBAA, 0, 0, 8'h0);
    chk("dn_first_lane", 32'(rdata_dn), 32'h0AA);
    cyc(0, 1, 16'h0, 0, 0, 8'h0);
    chk("dn_second_lane", 32'(rdata_dn), 32'h0BB);
    cyc(0, 1, 16'h0, 0, 0, 8'h0);
    chk("dn_empty_after", 32'(empty_dn), 32'd1);

    // Downsize: fill, rejected write, simultaneous wr/rd at full, drain.
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'($urandom), 0, 0, 8'h0);
    chk("dn_full_after8", 32'(full_dn), 32'd1);
    cyc(1, 0, 16'hDEAD, 0, 0, 8'h0);
    chk("dn_full_after9", 32'(full_dn), 32'd1);
    cyc(1, 1, 16'hBEEF, 0, 0, 8'h0);
    chk("dn_full_one_free", 32'(full_dn), 32'd1);
    for (int i = 0; i < 15; i++) cyc(0, 1, 16'h0, 0, 0, 8'h0);
    chk("dn_drained", 32'(empty_dn), 32'd1);

    // Upsize: one byte is not yet a readable word.
    cyc(0, 0, 16'h0, 1, 0, 8'hAA);
    chk("up_half_empty", 32'(empty_up), 32'd1);
    cyc(0, 0, 16'h0, 1, 0, 8'hBB);
    chk("up_word_ready", 32'(empty_up), 32'd0);
    chk("up_word_data", 32'(rdata_up), 32'h0BBAA);
    cyc(0, 0, 16'h0, 0, 1, 8'h0);
    chk("up_empty_after", 32'(empty_up), 32'd1);

    // Reset mid-stream discards data; traffic resumes normally.
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'($urandom), 1, 0, 8'($urandom));
    do_reset();
    chk("rst_empty_dn", 32'(empty_dn), 32'd1);
    chk("rst_full_dn",  32'(full_dn),  32'd0);
    chk("rst_empty_up", 32'(empty_up), 32'd1);
    chk("rst_full_up",  32'(full_up),  32'd0);
`ifdef WCF_LEVEL_EN
    chk("rst_level_dn", 32'(level_dn), 32'd0);
    chk("rst_level_up", 32'(level_up), 32'd0);
`endif
    cyc(1, 0, 16'h1234, 1, 0, 8'h56);
    cyc(0, 1, 16'h0, 1, 0, 8'h78);
    cyc(0, 1, 16'h0, 0, 1, 8'h0);
    cyc(0, 0, 16'h0, 0, 0, 8'h0);
    chk("post_rst_dn_empty", 32'(empty_dn), 32'd1);
    chk("post_rst_up_empty", 32'(empty_up), 32'd1);

    // Random streaming with gaps across pointer wrap on both instances.
    do_reset();
    c = 0;
    while (c < 4000 && !(wcnt_up == 40 && rcnt_up == 20 && wcnt_dn == 20 && rcnt_dn == 40)) begin
      cyc((wcnt_dn < 20) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) != 0, 16'($urandom),
          (wcnt_up < 40) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) == 0, 8'($urandom));
      c++;
    end
    cyc(0, 0, 16'h0, 0, 0, 8'h0);
    chk("rnd_up_words", 32'(rcnt_up), 32'd20);
    chk("rnd_dn_bytes", 32'(rcnt_dn), 32'd40);
    chk("sb_dn_drained", 32'(exp_dn.size()), 32'd0);
    chk("sb_up_drained", 32'(exp_up.size()), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/width_conv_fifo.md
WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3: log2 of the number of wide-word slots.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: narrow-side width in bits.
REQ-003 SHALL have parameter RATIO, default 2: wide/narrow width ratio, a power of two and at least 2.
REQ-004 SHALL have parameter MODE, default 0: 0 = wide write/narrow read (downsize), 1 = narrow write/wide read (upsize).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wr, input, 1 bit: write request.
REQ-008 SHALL have port rd, input, 1 bit: read request.
REQ-009 SHALL have port w_data, input, WW bits: write data; WW = RATIO*DATA_WIDTH when MODE=0, DATA_WIDTH when MODE=1.
REQ-010 SHALL have port r_data, output, RW bits: head data; RW = DATA_WIDTH when MODE=0, RATIO*DATA_WIDTH when MODE=1.
REQ-011 SHALL have port full, output, 1 bit: a write of one w_data word cannot be accepted.
REQ-012 SHALL have port empty, output, 1 bit: a read of one r_data word cannot be served.
REQ-013 SHALL have port level, output, ADDR_WIDTH+log2(RATIO)+1 bits: stored narrow units; present only under WCF_LEVEL_EN.

Function
REQ-014 SHALL store CAP = RATIO*2^ADDR_WIDTH narrow units, tracked by narrow-unit read and write pointers, each one bit wider than its address for wrap detection.
REQ-015 SHALL order lanes LSB-first: wide lane k = bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH], lane 0 oldest.
REQ-016 SHALL accept a write when wr=1 and full=0, advancing the write pointer by the w_data unit count (RATIO or 1); wr while full is ignored, with no state change.
REQ-017 SHALL accept a read when rd=1 and empty=0, advancing the read pointer by the r_data unit count; rd while empty is ignored.
REQ-018 SHALL present r_data combinationally from the current read pointer (first-word fall-through, zero read latency); r_data is don't-care while empty=1.
REQ-019 SHALL make written data visible on r_data and in the flags one cycle after the accepting clock edge.
REQ-020 SHALL derive flags from the stored count: MODE=0: full = (CAP-count < RATIO), empty = (count == 0); MODE=1: full = (count == CAP), empty = (count < RATIO).
REQ-021 SHALL evaluate simultaneous wr and rd against the pre-edge flags, performing each accepted side independently in the same cycle.
REQ-022 SHALL wrap pointers modulo 2*CAP with no data corruption across the wrap boundary.
REQ-023 SHALL keep every wide access slot-aligned (pointer multiple of RATIO) in all reachable states.

Reset
REQ-024 SHALL, on reset=1 at a clock edge, clear both pointers, giving empty=1, full=0 and level=0 on the next cycle; storage contents are not cleared.
REQ-025 SHALL give reset priority over concurrent wr and rd, discarding any in-flight data.

Configuration
REQ-026 SHALL, with WCF_LEVEL_EN defined, expose level as the count of stored narrow units (0..CAP), registered and updated on the same edge as the pointers.
REQ-027 SHALL, with WCF_LEVEL_EN undefined, omit the level port and its logic, with all other behaviour identical.

Structure
REQ-028 SHALL place in package wcf_pkg the mode enum (WCF_DOWN=0, WCF_UP=1) and the functions computing WW, RW and the pointer width.
REQ-029 SHALL implement pointer, count and flag logic in one sub-module, wcf_ctrl, with the storage array held in width_conv_fifo.

Verification
Parameters ADDR_WIDTH=3, DATA_WIDTH=8, RATIO=2, CAP=16 unless stated.
REQ-030 SHALL cover: MODE=0, write 16'hBBAA, then read x2 -> r_data 8'hAA then 8'hBB, empty=1 after the second read.
REQ-031 SHALL cover: MODE=0, 8 writes -> full=1 after the 8th; 9th write ignored; 16 reads return bytes in order.
REQ-032 SHALL cover: MODE=0 full, wr=1 and rd=1 in one cycle -> read accepted, write rejected, full stays 1 (1 unit free < RATIO).
REQ-033 SHALL cover: MODE=1, write 8'hAA -> empty stays 1; write 8'hBB -> empty=0, r_data=16'hBBAA.
REQ-034 SHALL cover: MODE=1, 40 bytes streamed with random wr/rd gaps -> all 20 wide words match the model across pointer wrap.
REQ-035 SHALL cover: 3 writes then reset=1 for one cycle -> empty=1, full=0, level=0; a subsequent write/read works normally.
